// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory waits and multi-cycle EX freezes.
// Optional macro HAZARD_STATS_EN adds the 16-bit saturating stallCycles counter output.
module hazard_control #(
   parameter int MULTI_CYCLES = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  idRs,
   input  logic [4:0]  idRt,
   input  logic [4:0]  exRt,
   input  logic        exMemRead,
   input  logic        exBranchTaken,
   input  logic        exMultiStart,
   input  logic        memBusy,
   output logic        pcNotEnable,
   output logic        ifIdNotEnable,
   output logic        idExNotEnable,
   output logic        ifIdClear,
   output logic        idExClear,
   output logic        exMemClear
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0] stallCycles
`endif
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      MEM_WAIT   = 2'd1,
      MULTI_WAIT = 2'd2
   } state_t;

   // Output vector order: pcNE, ifIdNE, idExNE, ifIdClr, idExClr, exMemClr
   localparam logic [5:0] OUT_IDLE   = 6'b000000;
   localparam logic [5:0] OUT_FREEZE = 6'b111000;
   localparam logic [5:0] OUT_MULTI  = 6'b111001;
   localparam logic [5:0] OUT_BRANCH = 6'b000110;
   localparam logic [5:0] OUT_LDUSE  = 6'b110010;
   localparam logic [3:0] CNT_LOAD   = 4'(MULTI_CYCLES - 1);

   state_t     state_r;
   state_t     state_next_s;
   logic [3:0] cnt_r;
   logic [3:0] cnt_next_s;
   logic [5:0] outs_s;
   logic [5:0] run_outs_s;
   state_t     run_next_s;
   logic       run_load_s;
   logic       run_multi_s;
   logic       load_use_s;

   function automatic logic load_use_f(
      input logic       mem_read,
      input logic [4:0] ex_rt,
      input logic [4:0] id_rs,
      input logic [4:0] id_rt
   );
      return mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
   endfunction

   assign load_use_s = load_use_f(exMemRead, exRt, idRs, idRt);

   // Shared RUN priority chain; multi-start is masked on the MULTI_WAIT release cycle
   always_comb begin
      run_outs_s  = OUT_IDLE;
      run_next_s  = RUN;
      run_load_s  = 1'b0;
      run_multi_s = exMultiStart && (state_r != MULTI_WAIT);
      if (memBusy) begin
         run_outs_s = OUT_FREEZE;
         run_next_s = MEM_WAIT;
      end else if (run_multi_s) begin
         run_outs_s = OUT_MULTI;
         run_next_s = MULTI_WAIT;
         run_load_s = 1'b1;
      end else if (exBranchTaken) begin
         run_outs_s = OUT_BRANCH;
      end else if (load_use_s) begin
         run_outs_s = OUT_LDUSE;
      end else begin
         run_outs_s = OUT_IDLE;
      end
   end

   // Next-state, counter and output selection
   always_comb begin
      outs_s       = OUT_IDLE;
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      if (reset) begin
         outs_s       = OUT_IDLE;
         state_next_s = RUN;
         cnt_next_s   = 4'd0;
      end else begin
         case (state_r)
            RUN, MEM_WAIT: begin
               // MEM_WAIT with memBusy low is identical to RUN; with memBusy high RUN re-freezes anyway
               outs_s       = run_outs_s;
               state_next_s = run_next_s;
               if (run_load_s) begin
                  cnt_next_s = CNT_LOAD;
               end else begin
                  cnt_next_s = cnt_r;
               end
            end
            MULTI_WAIT: begin
               if (cnt_r != 4'd1) begin
                  outs_s       = OUT_MULTI;
                  state_next_s = MULTI_WAIT;
                  cnt_next_s   = cnt_r - 4'd1;
               end else begin
                  outs_s       = run_outs_s;
                  state_next_s = run_next_s;
                  cnt_next_s   = 4'd0;
               end
            end
            default: begin
               outs_s       = OUT_IDLE;
               state_next_s = RUN;
               cnt_next_s   = 4'd0;
            end
         endcase
      end
   end

   // State and counter registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= RUN;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
      end
   end

   assign {pcNotEnable, ifIdNotEnable, idExNotEnable, ifIdClear, idExClear, exMemClear} = outs_s;

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_cnt_r;

   // Saturating count of PC-hold cycles
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt_r <= 16'd0;
      end else if (pcNotEnable && (stall_cnt_r != 16'hFFFF)) begin
         stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stallCycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Scoreboard bench for hazard_control (MULTI_CYCLES = 4); define HAZARD_STATS_EN to also check stallCycles.
module tb_hazard_control;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] idRs = 5'd0, idRt = 5'd0, exRt = 5'd0;
   logic       exMemRead = 1'b0, exBranchTaken = 1'b0, exMultiStart = 1'b0, memBusy = 1'b0;
   logic       pcNotEnable, ifIdNotEnable, idExNotEnable, ifIdClear, idExClear, exMemClear;
`ifdef HAZARD_STATS_EN
   logic [15:0] stallCycles;
`endif

   hazard_control #(.MULTI_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .idRs(idRs), .idRt(idRt), .exRt(exRt),
      .exMemRead(exMemRead), .exBranchTaken(exBranchTaken), .exMultiStart(exMultiStart),
      .memBusy(memBusy), .pcNotEnable(pcNotEnable), .ifIdNotEnable(ifIdNotEnable),
      .idExNotEnable(idExNotEnable), .ifIdClear(ifIdClear), .idExClear(idExClear),
      .exMemClear(exMemClear)
`ifdef HAZARD_STATS_EN
      , .stallCycles(stallCycles)
`endif
   );

   always #5 clock = ~clock;

   localparam logic [5:0] Z   = 6'b000000;
   localparam logic [5:0] FRZ = 6'b111000;
   localparam logic [5:0] MUL = 6'b111001;
   localparam logic [5:0] BR  = 6'b000110;
   localparam logic [5:0] LU  = 6'b110010;

   typedef struct {
      logic [5:0] exp;
      string      name;
   } exp_t;

   exp_t q[$];
   int   passed = 0;
   int   total  = 0;

   // Monitor: compare the DUT outputs against the oldest queued expectation
   always @(negedge clock) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [5:0] act;
         e   = q.pop_front();
         act = {pcNotEnable, ifIdNotEnable, idExNotEnable, ifIdClear, idExClear, exMemClear};
         total++;
         if (act === e.exp) passed++;
         else $display("FAIL %s: got %b expected %b (pcNE ifNE exNE ifClr exClr memClr)", e.name, act, e.exp);
      end
   end

   // One cycle of stimulus: rst, memBusy, multi, branch, memRead, exRt, idRs, idRt
   task automatic step(input logic r, input logic mb, input logic mu, input logic br,
                       input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [5:0] exp, input string name);
      exp_t e;
      @(posedge clock);
      #1;
      reset = r; memBusy = mb; exMultiStart = mu; exBranchTaken = br;
      exMemRead = mr; exRt = ert; idRs = rs; idRt = rt;
      e.exp = exp; e.name = name;
      q.push_back(e);
   endtask

   task automatic idle(input logic [5:0] exp, input string name);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, exp, name);
   endtask

`ifdef HAZARD_STATS_EN
   task automatic check_stats(input logic [15:0] exp, input string name);
      total++;
      if (stallCycles === exp) passed++;
      else $display("FAIL %s: stallCycles got %0d expected %0d", name, stallCycles, exp);
   endtask
`endif

   initial begin
      // Reset dominates any input pattern
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, Z, "reset_force_zero");
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, Z, "reset_force_zero2");
      idle(Z, "idle_after_reset");
`ifdef HAZARD_STATS_EN
      check_stats(16'd0, "stats_after_reset");
`endif
      // Load-use
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, LU, "loaduse_rs");
      idle(Z, "loaduse_one_cycle");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, LU, "loaduse_rt");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, Z,  "loaduse_r0");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, Z,  "no_load_match");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd8, 5'd10, Z, "load_no_match");
      // Branch beats load-use
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, BR, "branch_over_loaduse");
      // Multi-cycle held high: 3 freezes, release, freeze again
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, MUL, "multi_detect");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, MUL, "multi_freeze2");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, MUL, "multi_freeze3");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, Z,   "multi_release");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, MUL, "multi_again");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, MUL, "multi_again2");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, MUL, "multi_again3");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, BR,  "multi_release_branch");
      idle(Z, "idle_after_multi");
      // MULTI_WAIT ignores memBusy/branch; release cycle honours memBusy
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, MUL, "multi_detect_b");
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, MUL, "multi_ignores_mem");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, MUL, "multi_ignores_mem2");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, FRZ, "release_membusy");
      idle(Z, "mem_wait_exit");
      // Memory wait: 5 full freezes then load-use
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, FRZ, $sformatf("mem_freeze%0d", i));
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, LU, "mem_then_loaduse");
      idle(Z, "idle_after_mem");
      // MEM_WAIT release into multi-cycle
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, FRZ, "mem_over_multi");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, MUL, "memwait_to_multi");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, MUL, "memwait_multi2");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, MUL, "memwait_multi3");
      idle(Z, "memwait_multi_release");
      // Reset mid-MULTI_WAIT at cnt = 2
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, MUL, "pre_reset_multi");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, MUL, "pre_reset_multi2");
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, Z,   "reset_mid_multi");
      idle(Z, "after_mid_reset");
`ifdef HAZARD_STATS_EN
      check_stats(16'd0, "stats_mid_reset");
`endif
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, BR, "run_after_reset");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, MUL, "post_reset_multi");
      idle(MUL, "post_reset_multi2");
      idle(MUL, "post_reset_multi3");
      idle(Z, "post_reset_release");
`ifdef HAZARD_STATS_EN
      check_stats(16'd3, "stats_count");
`endif
      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
      if (q.size() > 0) begin
         total++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
